// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified memory between the IF
// stage (instruction fetch) and the MEM stage (lw/sw) of a MIPS pipeline.
// Data accesses win over fetches; each access runs over a variable-latency
// req/ack handshake, a global stall holds the pipeline while any request is
// outstanding, and a watchdog aborts accesses the memory never answers.
//
// Optional build macro: ARB_PERF_CNT_EN adds saturating 32-bit performance
// counters (stall_cycles, i_access_cnt, d_access_cnt).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr           fetch request, held until if_done
//   if_rdata/if_done         fetched instruction, completion pulse
//   d_read/d_write           load/store request, held until d_done
//   d_addr/d_wdata           data address, store data
//   d_rdata/d_done           load data, completion pulse
//   stall                    freeze all pipeline registers (combinational)
//   m_req/m_we/m_addr/m_wdata registered memory request
//   m_ack/m_rdata            memory completion, read data valid with m_ack
//   err                      sticky error (timeout or read+write request)
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              stall,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              err
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       i_access_cnt,
    output logic [31:0]       d_access_cnt
`endif
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        D_ACC = 2'd1,
        I_ACC = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic                req_nxt, we_nxt, err_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   wdata_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_nxt;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_nxt;
    logic                d_req;
    logic                tmo;
    logic                finish;
    logic [DATA_W-1:0]   fin_rdata;

    // Shared completion terms: an access ends on ack, or on timeout when no ack came
    always_comb begin
        d_req     = d_read | d_write;
        tmo       = (cnt == CNT_W'(TIMEOUT)) && !m_ack;
        finish    = (state != IDLE) && (m_ack || tmo);
        fin_rdata = m_ack ? m_rdata : '0;
    end

    // Done pulses, read-data pass-through and stall; suppressed while in reset
    always_comb begin
        if_done  = (state == I_ACC) && (m_ack || tmo) && !rst;
        d_done   = (state == D_ACC) && (m_ack || tmo) && !rst;
        if_rdata = if_done ? fin_rdata : if_rdata_q;
        d_rdata  = (d_done && !m_we) ? fin_rdata : d_rdata_q;
        stall    = (d_req & ~d_done) | (if_req & ~if_done);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next values of all registered outputs
    always_comb begin
        state_nxt    = state;
        req_nxt      = m_req;
        we_nxt       = m_we;
        addr_nxt     = m_addr;
        wdata_nxt    = m_wdata;
        cnt_nxt      = cnt;
        err_nxt      = err;
        if_rdata_nxt = if_rdata_q;
        d_rdata_nxt  = d_rdata_q;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                req_nxt = 1'b0;
                if (d_req) begin
                    // read+write together is flagged and executed as a store
                    state_nxt = D_ACC;
                    req_nxt   = 1'b1;
                    we_nxt    = d_write;
                    addr_nxt  = d_addr;
                    wdata_nxt = d_wdata;
                    if (d_read && d_write) begin
                        err_nxt = 1'b1;
                    end
                end else if (if_req) begin
                    state_nxt = I_ACC;
                    req_nxt   = 1'b1;
                    we_nxt    = 1'b0;
                    addr_nxt  = if_addr;
                end
            end

            D_ACC: begin
                if (finish) begin
                    cnt_nxt = '0;
                    if (!m_we) begin
                        d_rdata_nxt = fin_rdata;
                    end
                    if (tmo) begin
                        err_nxt = 1'b1;
                    end
                    // back-to-back fetch keeps m_req high with no bubble
                    if (m_ack && if_req) begin
                        state_nxt = I_ACC;
                        req_nxt   = 1'b1;
                        we_nxt    = 1'b0;
                        addr_nxt  = if_addr;
                    end else begin
                        state_nxt = IDLE;
                        req_nxt   = 1'b0;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            I_ACC: begin
                if (finish) begin
                    cnt_nxt      = '0;
                    if_rdata_nxt = fin_rdata;
                    if (tmo) begin
                        err_nxt = 1'b1;
                    end
                    // a pending data request is picked up from IDLE next cycle
                    state_nxt = IDLE;
                    req_nxt   = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
                req_nxt   = 1'b0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Registered memory interface, watchdog count, error and captured read data
    always_ff @(posedge clk) begin
        if (rst) begin
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            cnt        <= '0;
            err        <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            m_req      <= req_nxt;
            m_we       <= we_nxt;
            m_addr     <= addr_nxt;
            m_wdata    <= wdata_nxt;
            cnt        <= cnt_nxt;
            err        <= err_nxt;
            if_rdata_q <= if_rdata_nxt;
            d_rdata_q  <= d_rdata_nxt;
        end
    end

`ifdef ARB_PERF_CNT_EN
    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            i_access_cnt <= '0;
            d_access_cnt <= '0;
        end else begin
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (if_done && (i_access_cnt != '1)) begin
                i_access_cnt <= i_access_cnt + 32'd1;
            end
            if (d_done && (d_access_cnt != '1)) begin
                d_access_cnt <= d_access_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized request bundles checked by a scoreboard against a reference
// memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_read, d_write;
    logic [31:0] d_addr, d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        stall;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    wire         m_ack;
    wire  [31:0] m_rdata;
    logic        err;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] stall_cycles, i_access_cnt, d_access_cnt;
`endif

    logic        auto_en, auto_ack, man_ack;
    logic [31:0] auto_rdata, man_rdata;
    assign m_ack   = auto_ack | man_ack;
    assign m_rdata = man_ack ? man_rdata : auto_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .stall(stall),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata), .err(err)
`ifdef ARB_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .i_access_cnt(i_access_cnt),
        .d_access_cnt(d_access_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Initial memory contents, shared definition for responder and reference
    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h0101_0101) ^ 32'hA5A5_0F0F;
    endfunction

    // ---------------- memory responder (random latency) ----------------
    logic [31:0] mem [logic [31:0]];
    initial begin
        int wait_left;
        auto_ack   = 1'b0;
        auto_rdata = '0;
        wait_left  = $urandom_range(0, 4);
        forever begin
            @(posedge clk);
            #1;
            auto_ack = 1'b0;
            if (auto_en && m_req && !rst) begin
                if (wait_left == 0) begin
                    auto_ack = 1'b1;
                    if (m_we) begin
                        auto_rdata   = '0;
                        mem[m_addr]  = m_wdata;
                    end else begin
                        auto_rdata = mem.exists(m_addr) ? mem[m_addr] : init_val(m_addr);
                    end
                    wait_left = $urandom_range(0, 4);
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        is_d;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;
    exp_t        sbq[$];
    logic        sb_en = 1'b0;
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] last_drd;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    // Monitor: each completion is matched against the oldest expected access
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_en && (if_done || d_done)) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 32'(if_done) | 32'(d_done), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_kind", 32'(d_done), 32'(e.is_d));
                    chk("sb_m_addr", m_addr, e.addr);
                    chk("sb_m_we", 32'(m_we), 32'(e.we));
                    if (e.we) chk("sb_m_wdata", m_wdata, e.wdata);
                    if (e.is_d) chk("sb_d_rdata", d_rdata, e.rdata);
                    else        chk("sb_if_rdata", if_rdata, e.rdata);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Issue one bundle (data and/or fetch), hold each until its done
    task automatic bundle(input bit do_d, input bit wr, input logic [31:0] da,
                          input logic [31:0] dw, input bit do_i, input logic [31:0] ia);
        exp_t e;
        bit pd, pi, dd, id;
        int n;
        step();
        if (do_d) begin
            d_read = !wr; d_write = wr; d_addr = da; d_wdata = dw;
            e.is_d = 1'b1; e.addr = da; e.we = wr; e.wdata = dw;
            if (wr) begin
                e.rdata = last_drd;
                ref_mem[da] = dw;
            end else begin
                e.rdata = ref_rd(da);
                last_drd = e.rdata;
            end
            sbq.push_back(e);
        end
        if (do_i) begin
            if_req = 1'b1; if_addr = ia;
            e.is_d = 1'b0; e.addr = ia; e.we = 1'b0; e.wdata = '0;
            e.rdata = ref_rd(ia);
            sbq.push_back(e);
        end
        pd = do_d; pi = do_i; n = 0;
        while ((pd || pi) && n < 200) begin
            @(negedge clk);
            dd = d_done; id = if_done;
            step();
            if (dd) begin d_read = 1'b0; d_write = 1'b0; pd = 1'b0; end
            if (id) begin if_req = 1'b0; pi = 1'b0; end
            n++;
        end
        if (pd || pi) begin
            chk("bundle_wait_expired", 32'd1, 32'd0);
            d_read = 1'b0; d_write = 1'b0; if_req = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_read = 1'b0; d_write = 1'b0;
        d_addr = '0; d_wdata = '0; auto_en = 1'b0; man_ack = 1'b0; man_rdata = '0;
        last_drd = '0;
        repeat (3) step();
        rst = 1'b0;
        #1;
        // reset state
        chk("rst_m_req", 32'(m_req), 0);
        chk("rst_m_we", 32'(m_we), 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_stall", 32'(stall), 0);

        // fetch only, ack two cycles after m_req
        step(); if_req = 1'b1; if_addr = 32'h40; #1;
        chk("f_c0_stall", 32'(stall), 1);
        chk("f_c0_m_req", 32'(m_req), 0);
        step(); #1;
        chk("f_c1_m_req", 32'(m_req), 1);
        chk("f_c1_m_addr", m_addr, 32'h40);
        chk("f_c1_m_we", 32'(m_we), 0);
        chk("f_c1_stall", 32'(stall), 1);
        chk("f_c1_if_done", 32'(if_done), 0);
        step(); #1;
        chk("f_c2_stall", 32'(stall), 1);
        step(); man_ack = 1'b1; man_rdata = 32'h8C01_0004; #1;
        chk("f_c3_if_done", 32'(if_done), 1);
        chk("f_c3_if_rdata", if_rdata, 32'h8C01_0004);
        chk("f_c3_stall", 32'(stall), 0);
        step(); man_ack = 1'b0; if_req = 1'b0; #1;
        chk("f_c4_if_done", 32'(if_done), 0);
        chk("f_c4_if_rdata_hold", if_rdata, 32'h8C01_0004);
        chk("f_c4_m_req", 32'(m_req), 0);

        // collision: data first, fetch follows with no m_req gap
        step(); d_read = 1'b1; d_addr = 32'h100; if_req = 1'b1; if_addr = 32'h44; #1;
        chk("c_c0_stall", 32'(stall), 1);
        step(); man_ack = 1'b1; man_rdata = 32'h1234; #1;
        chk("c_c1_m_addr", m_addr, 32'h100);
        chk("c_c1_d_done", 32'(d_done), 1);
        chk("c_c1_d_rdata", d_rdata, 32'h1234);
        chk("c_c1_if_done", 32'(if_done), 0);
        chk("c_c1_stall", 32'(stall), 1);
        step(); d_read = 1'b0; man_rdata = 32'hABCD; #1;
        chk("c_c2_m_req", 32'(m_req), 1);
        chk("c_c2_m_addr", m_addr, 32'h44);
        chk("c_c2_if_done", 32'(if_done), 1);
        chk("c_c2_if_rdata", if_rdata, 32'hABCD);
        chk("c_c2_d_rdata", d_rdata, 32'h1234);
        step(); if_req = 1'b0; man_ack = 1'b0; #1;
        chk("c_c3_m_req", 32'(m_req), 0);

        // store: d_rdata must not change
        step(); d_write = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
        step(); man_ack = 1'b1; man_rdata = 32'h7777_7777; #1;
        chk("s_m_we", 32'(m_we), 1);
        chk("s_m_wdata", m_wdata, 32'hDEAD_BEEF);
        chk("s_m_addr", m_addr, 32'h200);
        chk("s_d_done", 32'(d_done), 1);
        chk("s_d_rdata", d_rdata, 32'h1234);
        step(); d_write = 1'b0; man_ack = 1'b0; #1;
        chk("s_after_d_rdata", d_rdata, 32'h1234);

        // stray ack in IDLE has no effect
        step(); man_ack = 1'b1; #1;
        chk("stray_d_done", 32'(d_done), 0);
        chk("stray_if_done", 32'(if_done), 0);
        step(); man_ack = 1'b0; #1;
        chk("stray_m_req", 32'(m_req), 0);

        // timeout on a fetch that never gets an ack
        step(); if_req = 1'b1; if_addr = 32'h80;
        for (int k = 1; k <= 15; k++) begin
            step(); #1;
            chk("t_no_done", 32'(if_done), 0);
            chk("t_m_req", 32'(m_req), 1);
        end
        step(); #1;
        chk("t_if_done", 32'(if_done), 1);
        chk("t_if_rdata", if_rdata, 0);
        step(); if_req = 1'b0; #1;
        chk("t_err", 32'(err), 1);
        chk("t_m_req_drop", 32'(m_req), 0);
        repeat (3) step();
        #1;
        chk("t_err_sticky", 32'(err), 1);

        // reset in the middle of a data access
        step(); d_read = 1'b1; d_addr = 32'h300;
        step(); #1;
        chk("r_m_req", 32'(m_req), 1);
        step(); rst = 1'b1;
        step(); rst = 1'b0; d_read = 1'b0; man_ack = 1'b1; man_rdata = 32'h5555; #1;
        chk("r_m_req_low", 32'(m_req), 0);
        chk("r_no_d_done", 32'(d_done), 0);
        chk("r_err_clear", 32'(err), 0);
        step(); man_ack = 1'b0; #1;
        chk("r_d_rdata", d_rdata, 0);

        // illegal read+write: executed as store, err set
        step(); d_read = 1'b1; d_write = 1'b1; d_addr = 32'h400; d_wdata = 32'h55;
        step(); #1;
        chk("i_m_we", 32'(m_we), 1);
        step(); man_ack = 1'b1; #1;
        chk("i_d_done", 32'(d_done), 1);
        step(); d_read = 1'b0; d_write = 1'b0; man_ack = 1'b0; #1;
        chk("i_err", 32'(err), 1);
`ifdef ARB_PERF_CNT_EN
        chk("p_stall_cycles", stall_cycles, 2);
        chk("p_d_access_cnt", d_access_cnt, 1);
        chk("p_i_access_cnt", i_access_cnt, 0);
`endif

        // randomized bundles against the reference memory
        rst = 1'b1; step(); rst = 1'b0;
        last_drd = '0;
        auto_en = 1'b1;
        sb_en = 1'b1;
        for (int b = 0; b < 60; b++) begin
            int kind;
            kind = $urandom_range(0, 2);
            bundle(kind != 1, 1'($urandom_range(0, 1)), {26'd0, 4'($urandom_range(0, 15)), 2'b00},
                   $urandom, kind != 0, {26'd0, 4'($urandom_range(0, 15)), 2'b00});
            repeat ($urandom_range(0, 2)) step();
        end
        repeat (4) step();
        chk("sb_drained", 32'(sbq.size()), 0);
        chk("rand_err", 32'(err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
